// File: rtl/adder_pipe.sv
// Two-stage pipelined carry-select adder with valid/ready flow control on both sides.
// Stage 1 precomputes per-block sums for both carry-ins; stage 2 resolves the carry chain.
module adder_pipe #(
    parameter int unsigned WIDTH = 25,
    parameter int unsigned BLOCK = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_overflow,
    output logic [31:0]      out_count
);

    localparam int unsigned NBLK = WIDTH / BLOCK;

    logic [NBLK-1:0][BLOCK-1:0] blk_sum0;
    logic [NBLK-1:0][BLOCK-1:0] blk_sum1;
    logic [NBLK-1:0]            blk_c0;
    logic [NBLK-1:0]            blk_c1;

    logic [NBLK-1:0][BLOCK-1:0] s1_sum0;
    logic [NBLK-1:0][BLOCK-1:0] s1_sum1;
    logic [NBLK-1:0]            s1_c0;
    logic [NBLK-1:0]            s1_c1;
    logic                       s1_valid;

    logic [WIDTH-1:0]           res_sum;
    logic                       res_ovf;
    logic                       s1_en;
    logic                       s2_en;

    // A stage may load when it is empty or its contents move on this cycle.
    assign s2_en    = !out_valid || out_ready;
    assign s1_en    = !s1_valid || s2_en;
    assign in_ready = s1_en;

    // Per-block speculative sums; block 0 only ever sees carry-in 0.
    always_comb begin
        blk_sum0 = '0;
        blk_sum1 = '0;
        blk_c0   = '0;
        blk_c1   = '0;
        for (int k = 0; k < int'(NBLK); k++) begin
            {blk_c0[k], blk_sum0[k]} = {1'b0, in_a[k*BLOCK +: BLOCK]}
                                     + {1'b0, in_b[k*BLOCK +: BLOCK]};
            if (k != 0) begin
                {blk_c1[k], blk_sum1[k]} = {1'b0, in_a[k*BLOCK +: BLOCK]}
                                         + {1'b0, in_b[k*BLOCK +: BLOCK]}
                                         + (BLOCK+1)'(1);
            end
        end
    end

    // Carry-select resolution from the stage-1 registers.
    always_comb begin
        logic carry;
        carry   = 1'b0;
        res_sum = '0;
        for (int k = 0; k < int'(NBLK); k++) begin
            res_sum[k*BLOCK +: BLOCK] = carry ? s1_sum1[k] : s1_sum0[k];
            carry                     = carry ? s1_c1[k] : s1_c0[k];
        end
        res_ovf = carry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid     <= 1'b0;
            s1_sum0      <= '0;
            s1_sum1      <= '0;
            s1_c0        <= '0;
            s1_c1        <= '0;
            out_valid    <= 1'b0;
            out_sum      <= '0;
            out_overflow <= 1'b0;
            out_count    <= '0;
        end else begin
            if (s2_en) begin
                out_valid    <= s1_valid;
                out_sum      <= res_sum;
                out_overflow <= res_ovf;
            end
            if (s1_en) begin
                s1_valid <= in_valid;
                s1_sum0  <= blk_sum0;
                s1_sum1  <= blk_sum1;
                s1_c0    <= blk_c0;
                s1_c1    <= blk_c1;
            end
            if (out_valid && out_ready) begin
                out_count <= out_count + 32'd1;
            end
        end
    end

endmodule

// File: doc/adder_pipe.md
# adder_pipe

Pipelined, flow-controlled 25-bit unsigned carry-select adder. It consumes operand pairs from a valid/ready stream and returns {overflow, sum} results on a second valid/ready stream, with an identical result format to the combinational adder's {overflow, sum}. It lets the adder sit between buffered datapath blocks and lets the operand/ideal-result file flow run against registered hardware, including stalls.

## Interface
- WIDTH, 25, operand and sum width; must be an integer multiple of BLOCK
- BLOCK, 5, carry-select block width; NBLK = WIDTH/BLOCK blocks
- clk  input  1  rising-edge clock
- rst  input  1  reset; one clock, reset is synchronous and active-high
- in_valid  input  1  operand pair present
- in_ready  output  1  adder accepts the pair this cycle
- in_a  input  WIDTH  operand A, unsigned
- in_b  input  WIDTH  operand B, unsigned
- out_valid  output  1  result present
- out_ready  input  1  downstream accepts the result this cycle
- out_sum  output  WIDTH  (in_a + in_b) mod 2^WIDTH
- out_overflow  output  1  carry out of bit WIDTH-1
- out_count  output  32  number of results consumed since reset; wraps

## Operation
- Transfer on a port occurs when valid and ready are both 1 at a rising edge.
- Stage 1, on input transfer, registers the following for each block k:
  - sum0[k] and c0[k]: the block sum and carry with carry-in 0.
  - sum1[k] and c1[k]: the block sum and carry with carry-in 1.
  - Block 0 uses only carry-in 0.
  - s1_valid is set.
- Stage 2 resolves the carry chain from the stage-1 registers:
  - cin[0] = 0.
  - cin[k+1] = cin[k] ? c1[k] : c0[k].
  - Block sum k = cin[k] ? sum1[k] : sum0[k].
  - out_overflow = cin[NBLK].
  - The results are registered into the output register and out_valid is set.
- Flow control:
  - s2_en = !out_valid | out_ready.
  - s1_en = !s1_valid | s2_en.
  - in_ready = s1_en.
  - These are combinational; in_ready depends on out_ready.
- Register updates:
  - When s2_en is 1, the output register loads stage 1 and out_valid <= s1_valid.
  - When s1_en is 1, stage 1 loads the inputs and s1_valid <= in_valid.
- While out_valid=1 and out_ready=0, out_sum and out_overflow are held stable.
- out_count increments by 1 on every output transfer and wraps from 0xFFFFFFFF to 0.
- Data beyond stage 1 is a pure function of the accepted operands. No result is dropped, duplicated or reordered.

## Timing
- Reset values:
  - in_ready = 1 in the cycle after reset deasserts, because all stages are empty.
  - out_valid = 0, s1_valid = 0, out_sum = 0, out_overflow = 0, out_count = 0.
- rst asserted mid-operation discards all in-flight pairs at that edge. No output transfer counts for that cycle.
- Latency: a pair accepted at edge N produces out_valid=1 after edge N+1, i.e. it is transferable at edge N+2 when out_ready is held high.
- Throughput: one pair per cycle with out_ready held at 1.
- Stall capacity is 2 pairs (stage 1 plus output register). With out_ready=0, in_ready drops after 2 accepted pairs.
- Simultaneous output transfer and input transfer in the same cycle is legal and keeps the pipeline full.
- in_a and in_b are ignored when in_valid=0. out_sum and out_overflow are don't-care when out_valid=0, but must not change while out_valid=1 and out_ready=0.

## Test plan
- Carry corners, streamed back-to-back with out_ready=1. Each pair produces a result 2 cycles after acceptance, and the results stay in order.

  | in_a | in_b | out_overflow | out_sum |
  |---|---|---|---|
  | 1FFFFFF | 0000001 | 1 | 0000000 |
  | 0AAAAAA | 1555555 | 0 | 1FFFFFF |
  | 1FFFFFF | 1FFFFFF | 1 | 1FFFFFE |
  | 0000000 | 0000000 | 0 | 0000000 |
  | 00FFFFF | 0000001 | 0 | 0100000 |

- Backpressure:
  - Stimulus: hold out_ready=0 and stream 4 pairs.
  - Required: in_ready goes low after exactly 2 acceptances.
  - Required: out_sum is held stable for 6 cycles.
  - Required: on raising out_ready, the 4 results drain in order at 1 per cycle, and out_count = 4.
- Random ready:
  - Stimulus: 10,000 random operand pairs from a file, with randomized in_valid and out_ready.
  - Required: every {out_overflow, out_sum} matches the 26-bit ideal value in order.
  - Required: out_count = 10000.
- Reset mid-stream:
  - Stimulus: assert rst for 1 cycle with 2 pairs in flight.
  - Required: out_valid = 0 and out_count = 0 on the next cycle.
  - Required: in_ready = 1, and the first pair accepted after reset appears 2 cycles later.
- out_count wrap:
  - Stimulus: force out_count to FFFFFFFF, then perform one output transfer.
  - Required: out_count = 00000000.
